// File: rtl/mips_bus_bridge.sv
// mips_bus_bridge: CPU-to-RAM bridge with fixed wait states. Define MIPS_BRIDGE_ALIGN_CHECK_EN
// to flag misaligned accesses on err and suppress their RAM strobes.
module mips_bus_bridge #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       address,
    input  logic              read,
    input  logic              write,
    input  logic [3:0]        byte_en,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic [3:0]  be_q;
    logic [31:0] rd_q;
    logic        wr_q, mis_q, err_q, mis_in, unused_ok;
`ifdef MIPS_BRIDGE_ALIGN_CHECK_EN
    assign mis_in    = |address[1:0];
    assign unused_ok = ^address[31:ADDR_W+2];
`else
    assign mis_in    = 1'b0;
    assign unused_ok = ^{address[31:ADDR_W+2], address[1:0]};
`endif
    assign err = err_q;
    always_comb begin
        state_nxt   = state;
        case (state)
            IDLE:    if (read | write) state_nxt = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
            WAIT:    if (cnt <= 3'd1) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        waitrequest = state != DONE;
        mem_re      = state == ACCESS && !wr_q && !mis_q;
        mem_we      = (state == ACCESS && wr_q && !mis_q) ? be_q : 4'b0000;
        readdata    = (state == DONE && !wr_q) ? (mis_q ? 32'h0 : mem_rdata) : rd_q;
    end
    // A write wins when read and write arrive together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            be_q      <= 4'b0000;
            rd_q      <= 32'h0;
            wr_q      <= 1'b0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (read | write)) begin
                mem_addr  <= address[ADDR_W+1:2];
                be_q      <= byte_en;
                mem_wdata <= writedata;
                wr_q      <= write;
                mis_q     <= mis_in;
                err_q     <= err_q | mis_in;
                cnt       <= 3'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - 3'd1;
            end
            if (state == DONE && !wr_q) rd_q <= readdata;
        end
    end
endmodule

// File: tb/tb_mips_bus_bridge.sv
// tb_mips_bus_bridge: directed checks of the bridge with WAIT_CYCLES=1 and WAIT_CYCLES=0,
// each attached to a small behavioural RAM.
module tb_mips_bus_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, writedata;
    logic [3:0]  byte_en;
    logic        read1, write1, read0, write0;
    logic [31:0] readdata1, readdata0, mem_wdata1, mem_wdata0;
    logic [31:0] mem_rdata1 = 32'h0, mem_rdata0 = 32'h0;
    logic [15:0] mem_addr1, mem_addr0;
    logic        waitrequest1, waitrequest0, mem_re1, mem_re0, err1, err0;
    logic [3:0]  mem_we1, mem_we0;
    logic [31:0] ram1 [0:255];
    logic [31:0] ram0 [0:255];
    logic        loaded = 1'b0;
    int          re_cnt1 = 0, we_cnt1 = 0, re_cnt0 = 0;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    mips_bus_bridge #(.WAIT_CYCLES(1), .ADDR_W(16)) dut1 (
        .clk(clk), .rst(rst), .address(address), .read(read1), .write(write1),
        .byte_en(byte_en), .writedata(writedata), .readdata(readdata1),
        .waitrequest(waitrequest1), .mem_addr(mem_addr1), .mem_re(mem_re1),
        .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .err(err1));

    mips_bus_bridge #(.WAIT_CYCLES(0), .ADDR_W(16)) dut0 (
        .clk(clk), .rst(rst), .address(address), .read(read0), .write(write0),
        .byte_en(byte_en), .writedata(writedata), .readdata(readdata0),
        .waitrequest(waitrequest0), .mem_addr(mem_addr0), .mem_re(mem_re0),
        .mem_we(mem_we0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .err(err0));

    always @(posedge clk) begin
        if (!loaded) begin
            ram1[16] <= 32'hCAFE_F00D;
            ram1[17] <= 32'hAABB_CCDD;
            ram1[18] <= 32'h1111_1111;
            loaded   <= 1'b1;
        end else begin
            if (mem_re1) mem_rdata1 <= ram1[mem_addr1[7:0]];
            for (int i = 0; i < 4; i++)
                if (mem_we1[i]) ram1[mem_addr1[7:0]][8*i +: 8] <= mem_wdata1[8*i +: 8];
            if (mem_re1) re_cnt1 <= re_cnt1 + 1;
            if (|mem_we1) we_cnt1 <= we_cnt1 + 1;
        end
    end

    always @(posedge clk) begin
        if (mem_re0) mem_rdata0 <= ram0[mem_addr0[7:0]];
        for (int j = 0; j < 4; j++)
            if (mem_we0[j]) ram0[mem_addr0[7:0]][8*j +: 8] <= mem_wdata0[8*j +: 8];
        if (mem_re0) re_cnt0 <= re_cnt0 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; read1 = 1'b0; write1 = 1'b0; read0 = 1'b0; write0 = 1'b0;
        address = 32'h0; byte_en = 4'h0; writedata = 32'h0;
        cyc(2);
        chk("rst_wait", waitrequest1, 1);
        chk("rst_rdata", readdata1, 0);
        chk("rst_re", mem_re1, 0);
        chk("rst_we", mem_we1, 0);
        chk("rst_addr", mem_addr1, 0);
        chk("rst_wdata", mem_wdata1, 0);
        chk("rst_err", err1, 0);
        chk("rst_wait0", waitrequest0, 1);
        rst = 1'b1;
        cyc(1);
        // read 0x40, expect completion in cycle 3
        address = 32'h40; read1 = 1'b1;
        cyc(1); chk("rd_c1_wait", waitrequest1, 1); chk("rd_c1_re", mem_re1, 0);
        cyc(1); chk("rd_c2_re", mem_re1, 1); chk("rd_c2_addr", mem_addr1, 16'h10);
        chk("rd_c2_wait", waitrequest1, 1);
        cyc(1); chk("rd_c3_wait", waitrequest1, 0); chk("rd_c3_data", readdata1, 32'hCAFE_F00D);
        read1 = 1'b0;
        cyc(1); chk("rd_hold", readdata1, 32'hCAFE_F00D); chk("rd_idle_wait", waitrequest1, 1);
        chk("rd_re_pulses", re_cnt1, 1);
        // partial write 0x44, lanes 0011
        address = 32'h44; byte_en = 4'b0011; writedata = 32'h1234_5678; write1 = 1'b1;
        cyc(1); chk("wr_c1_we", mem_we1, 0);
        cyc(1); chk("wr_c2_we", mem_we1, 4'b0011); chk("wr_c2_addr", mem_addr1, 16'h11);
        chk("wr_c2_wdata", mem_wdata1, 32'h1234_5678); chk("wr_c2_re", mem_re1, 0);
        cyc(1); chk("wr_c3_wait", waitrequest1, 0); chk("wr_rdata_hold", readdata1, 32'hCAFE_F00D);
        write1 = 1'b0;
        cyc(1);
        // read back, request held through DONE to check no re-acceptance
        read1 = 1'b1;
        cyc(3); chk("rb_data", readdata1, 32'hAABB_5678); chk("rb_wait", waitrequest1, 0);
        cyc(1); chk("b2b_idle_wait", waitrequest1, 1); chk("b2b_idle_re", mem_re1, 0);
        cyc(1); chk("b2b_wait_re", mem_re1, 0);
        cyc(1); chk("b2b_acc_re", mem_re1, 1);
        cyc(1); chk("b2b_done", waitrequest1, 0);
        read1 = 1'b0;
        cyc(1); chk("b2b_pulses", re_cnt1, 3); chk("we_pulses", we_cnt1, 1);
        // empty byte mask write
        address = 32'h48; byte_en = 4'b0000; writedata = 32'hDEAD_BEEF; write1 = 1'b1;
        cyc(2); chk("be0_we", mem_we1, 0); chk("be0_re", mem_re1, 0); chk("be0_addr", mem_addr1, 16'h12);
        cyc(1); chk("be0_wait", waitrequest1, 0);
        write1 = 1'b0;
        cyc(1);
        read1 = 1'b1;
        cyc(3); chk("be0_rb", readdata1, 32'h1111_1111);
        read1 = 1'b0;
        cyc(1);
        // reset during WAIT of a write
        address = 32'h40; byte_en = 4'b1111; writedata = 32'hFFFF_FFFF; write1 = 1'b1;
        cyc(1); chk("ab_wait_state", waitrequest1, 1);
        #1 rst = 1'b0; write1 = 1'b0;
        #1;
        chk("ab_wait", waitrequest1, 1); chk("ab_we", mem_we1, 0); chk("ab_addr", mem_addr1, 0);
        chk("ab_wdata", mem_wdata1, 0); chk("ab_rdata", readdata1, 0);
        cyc(2); rst = 1'b1;
        cyc(3); chk("ab_no_write", we_cnt1, 1);
        read1 = 1'b1;
        cyc(3); chk("ab_rb", readdata1, 32'hCAFE_F00D);
        read1 = 1'b0;
        cyc(1);
`ifdef MIPS_BRIDGE_ALIGN_CHECK_EN
        address = 32'h42; byte_en = 4'b1111; writedata = 32'h0; write1 = 1'b1;
        cyc(1); chk("al_err", err1, 1);
        cyc(1); chk("al_we", mem_we1, 0);
        cyc(1); chk("al_wait", waitrequest1, 0);
        write1 = 1'b0;
        cyc(1);
        address = 32'h40; read1 = 1'b1;
        cyc(3); chk("al_rb", readdata1, 32'hCAFE_F00D); chk("al_sticky", err1, 1);
        read1 = 1'b0;
        cyc(1);
        address = 32'h41; read1 = 1'b1;
        cyc(3); chk("al_rd_zero", readdata1, 0); chk("al_wait2", waitrequest1, 0);
        read1 = 1'b0;
        cyc(1);
        rst = 1'b0;
        #1 chk("al_clr", err1, 0);
        cyc(1); rst = 1'b1;
        cyc(1);
`else
        // low address bits ignored without the alignment check
        address = 32'h4E; byte_en = 4'b1111; writedata = 32'h55AA_55AA; write1 = 1'b1;
        cyc(2); chk("mis_addr", mem_addr1, 16'h13); chk("mis_we", mem_we1, 4'b1111);
        cyc(1); chk("mis_wait", waitrequest1, 0); chk("mis_err", err1, 0);
        write1 = 1'b0;
        cyc(1);
`endif
        // WAIT_CYCLES=0 with read and write together
        address = 32'h0; byte_en = 4'b1111; writedata = 32'h0BAD_F00D; read0 = 1'b1; write0 = 1'b1;
        cyc(1); chk("z_we", mem_we0, 4'b1111); chk("z_re", mem_re0, 0); chk("z_c1_wait", waitrequest0, 1);
        cyc(1); chk("z_c2_wait", waitrequest0, 0);
        read0 = 1'b0; write0 = 1'b0;
        cyc(1); chk("z_ram", ram0[0], 32'h0BAD_F00D); chk("z_no_re", re_cnt0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mips_bus_bridge.md
MIPS_BUS_BRIDGE -- requirements
Module: mips_bus_bridge

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: extra wait states inserted per access, legal range 0..7.
REQ-002 SHALL have parameter ADDR_W, default 16: width of the word address presented to the RAM.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port address  input  32  CPU byte address.
REQ-006 SHALL have port read  input  1  CPU read request.
REQ-007 SHALL have port write  input  1  CPU write request.
REQ-008 SHALL have port byte_en  input  4  CPU byte lanes; bit i selects byte i.
REQ-009 SHALL have port writedata  input  32  CPU write data.
REQ-010 SHALL have port readdata  output  32  read data to CPU.
REQ-011 SHALL have port waitrequest  output  1  stall to CPU; 1 = hold request stable.
REQ-012 SHALL have port mem_addr  output  ADDR_W  RAM word address.
REQ-013 SHALL have port mem_re  output  1  RAM read strobe.
REQ-014 SHALL have port mem_we  output  4  RAM per-byte write strobes.
REQ-015 SHALL have port mem_wdata  output  32  RAM write data.
REQ-016 SHALL have port mem_rdata  input  32  RAM read data, valid the cycle after mem_re.
REQ-017 SHALL have port err  output  1  sticky misaligned-access flag.

Function
REQ-018 SHALL implement FSM IDLE -> WAIT -> ACCESS -> DONE -> IDLE.
REQ-019 In IDLE with read|write = 1, SHALL latch address[ADDR_W+1:2], byte_en, writedata and op type, load the wait counter with WAIT_CYCLES, and go to WAIT (or straight to ACCESS when WAIT_CYCLES = 0).
REQ-020 WAIT SHALL decrement the counter each cycle and go to ACCESS when it reaches 0.
REQ-021 ACCESS SHALL drive mem_addr from the latch for exactly one cycle, with mem_re = 1 for reads or mem_we = latched byte_en for writes, then go to DONE.
REQ-022 DONE SHALL drive waitrequest = 0 and, for reads, readdata = mem_rdata; it SHALL always return to IDLE next cycle.
REQ-023 waitrequest SHALL be 1 in every state except DONE, including IDLE.
REQ-024 Latency: a request first sampled in cycle 0 SHALL see waitrequest = 0 in cycle WAIT_CYCLES+2.
REQ-025 read and write both 1 SHALL be treated as a write; the read is ignored.
REQ-026 A write with byte_en = 0000 SHALL complete normally with mem_we = 0000.
REQ-027 readdata SHALL hold its last value outside DONE-of-read; mem_re and mem_we SHALL be 0 outside ACCESS.
REQ-028 Back-to-back: a request held high across DONE SHALL NOT be re-accepted in that DONE cycle; a new request is accepted only from IDLE.
REQ-029 mem_wdata SHALL equal the latched writedata whenever mem_we != 0.

Reset
REQ-030 rst = 0 SHALL asynchronously force state IDLE, counter 0, readdata 0, waitrequest 1, mem_re 0, mem_we 0000, mem_addr 0, mem_wdata 0, err 0.
REQ-031 Reset asserted mid-access SHALL abort the transaction with no RAM write issued after the reset edge.

Configuration
REQ-032 With macro MIPS_BRIDGE_ALIGN_CHECK_EN defined: an access with address[1:0] != 00 SHALL set err (sticky until reset), suppress mem_we/mem_re in ACCESS, return readdata = 32'h0000_0000 for reads, and still complete with normal latency.
REQ-033 Without MIPS_BRIDGE_ALIGN_CHECK_EN: err SHALL be tied 0 and address[1:0] SHALL be ignored.

Verification
REQ-034 WAIT_CYCLES=1, RAM word 0x10 = 32'hCAFE_F00D, read address 32'h40 -> waitrequest low in cycle 3, readdata = 32'hCAFE_F00D, one mem_re pulse.
REQ-035 Write address 32'h44, byte_en 0011, data 32'h1234_5678 -> single ACCESS cycle with mem_addr 0x11, mem_we 0011; subsequent read returns old upper 16 bits with lower half 16'h5678.
REQ-036 WAIT_CYCLES=0, read and write both high at 32'h0 -> write performed, no mem_re, waitrequest low in cycle 2.
REQ-037 rst pulsed low during WAIT of a write -> mem_we never asserted, outputs at reset values, next read sees unmodified RAM.
REQ-038 With MIPS_BRIDGE_ALIGN_CHECK_EN, write to 32'h42 -> err = 1, mem_we stays 0000, err remains 1 over following aligned accesses until rst.
